// File: rtl/pulse_gen_multi_if.sv
// Control/status bundle for pulse_gen_multi: level inputs, shared pulse settings,
// and per-channel pulse and missed-edge outputs.
interface pulse_gen_multi_if #(
    parameter int CHANNELS = 4,
    parameter int LEN_BITS = 4
);
    logic [CHANNELS-1:0] en;
    logic [1:0]          mode;
    logic [LEN_BITS-1:0] pulse_len;
    logic                retrig;
    logic                clr_missed;
    logic [CHANNELS-1:0] pulse_out;
    logic [CHANNELS-1:0] missed;

    modport master (
        output en, mode, pulse_len, retrig, clr_missed,
        input  pulse_out, missed
    );

    modport slave (
        input  en, mode, pulse_len, retrig, clr_missed,
        output pulse_out, missed
    );
endinterface

// File: rtl/pulse_gen_multi.sv
// Multi-channel edge-to-pulse generator: each channel turns a qualifying edge on its
// synchronised level input into a fixed-width strobe, with optional retrigger.
//
// state | meaning
// IDLE  | no pulse; a qualifying edge loads cnt and enters PULSE
// PULSE | pulse_out high; cnt counts down, leaves after the cnt = 1 cycle
module pulse_gen_multi #(
    parameter int CHANNELS    = 4,
    parameter int LEN_BITS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pulse_gen_multi_if.slave  bus
);

    typedef enum logic {IDLE, PULSE} state_e;

    localparam logic [LEN_BITS-1:0] ONE = LEN_BITS'(1);

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] qual;
    logic [CHANNELS-1:0] missed_set;
    logic [CHANNELS-1:0] missed_q;
    logic [CHANNELS-1:0] missed_d;
    logic [LEN_BITS-1:0] len_eff;

    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [LEN_BITS-1:0] cnt_q   [CHANNELS];
    logic [LEN_BITS-1:0] cnt_d   [CHANNELS];

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= bus.en[ch];
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s[ch] = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s[ch] = bus.en[ch];
        end

        // Output comes straight from the state flop, so async reset drops it at once.
        assign bus.pulse_out[ch] = (state_q[ch] == PULSE);
    end

    assign rise     = s & ~prev_q;
    assign fall     = ~s & prev_q;
    assign len_eff  = (bus.pulse_len == '0) ? ONE : bus.pulse_len;
    assign missed_d = missed_set | (missed_q & ~{CHANNELS{bus.clr_missed}});
    assign bus.missed = missed_q;

    always_comb begin
        qual = '0;
        unique case (bus.mode)
            2'b00:   qual = rise;
            2'b01:   qual = fall;
            2'b10:   qual = rise | fall;
            default: qual = '0;
        endcase
    end

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            state_d[ch]    = state_q[ch];
            cnt_d[ch]      = cnt_q[ch];
            missed_set[ch] = 1'b0;
            case (state_q[ch])
                IDLE: begin
                    if (qual[ch]) begin
                        state_d[ch] = PULSE;
                        cnt_d[ch]   = len_eff;
                    end
                end
                PULSE: begin
                    if (qual[ch] && bus.retrig) begin
                        cnt_d[ch] = len_eff;
                    end else begin
                        // A dropped edge still lets the running count expire normally.
                        missed_set[ch] = qual[ch];
                        if (cnt_q[ch] <= ONE) begin
                            state_d[ch] = IDLE;
                            cnt_d[ch]   = '0;
                        end else begin
                            cnt_d[ch] = cnt_q[ch] - ONE;
                        end
                    end
                end
                default: begin
                    state_d[ch] = IDLE;
                    cnt_d[ch]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q   <= '0;
            missed_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
                cnt_q[ch]   <= '0;
            end
        end else begin
            prev_q   <= s;
            missed_q <= missed_d;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi (4 channels, 4-bit length, 2 sync stages).
module tb_pulse_gen_multi;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    pulse_gen_multi_if #(.CHANNELS(4), .LEN_BITS(4)) bus ();

    pulse_gen_multi #(.CHANNELS(4), .LEN_BITS(4), .SYNC_STAGES(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.en = '0; bus.mode = 2'b00; bus.pulse_len = 4'd3;
        bus.retrig = 1'b0; bus.clr_missed = 1'b0;
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (bus.pulse_out !== 4'b0000) begin
            failures++; $display("FAIL reset_pulse_out got=%b exp=0000", bus.pulse_out);
        end
        checks++;
        if (bus.missed !== 4'b0000) begin
            failures++; $display("FAIL reset_missed got=%b exp=0000", bus.missed);
        end
        #3 rst = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (bus.pulse_out !== 4'b0000) begin
            failures++; $display("FAIL post_reset_idle got=%b exp=0000", bus.pulse_out);
        end
    endtask

    task automatic test_rising_basic();
        logic [7:0] tr;
        logic       others;
        tr = '0; others = 1'b0;
        bus.mode = 2'b00; bus.pulse_len = 4'd3;
        bus.en[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tr[i]  = bus.pulse_out[0];
            others = others | (|bus.pulse_out[3:1]);
        end
        checks++;
        if (tr !== 8'b0001_1100) begin
            failures++; $display("FAIL rise_len3_trace got=%b exp=00011100", tr);
        end
        checks++;
        if (others !== 1'b0) begin
            failures++; $display("FAIL rise_other_channels got=%b exp=0", others);
        end
        checks++;
        if (bus.missed !== 4'b0000) begin
            failures++; $display("FAIL rise_missed got=%b exp=0000", bus.missed);
        end
        bus.en[0] = 1'b0;
        tr = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            tr[i] = bus.pulse_out[0];
        end
        checks++;
        if (tr !== 8'b0) begin
            failures++; $display("FAIL rise_mode_ignores_fall got=%b exp=00000000", tr);
        end
    endtask

    task automatic test_falling();
        logic [5:0] tr;
        bus.mode = 2'b01; bus.pulse_len = 4'd0;
        tr = '0;
        bus.en[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tr[i] = bus.pulse_out[1];
        end
        checks++;
        if (tr !== 6'b000000) begin
            failures++; $display("FAIL fall_mode_ignores_rise got=%b exp=000000", tr);
        end
        tr = '0;
        bus.en[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            tr[i] = bus.pulse_out[1];
        end
        checks++;
        if (tr !== 6'b000100) begin
            failures++; $display("FAIL fall_len0_trace got=%b exp=000100", tr);
        end
    endtask

    task automatic test_both();
        logic [19:0] tr;
        bus.mode = 2'b10; bus.pulse_len = 4'd0;
        tr = '0;
        for (int i = 0; i < 20; i++) begin
            if ((i % 4) == 0 && i < 16) bus.en[2] = ~bus.en[2];
            tick();
            tr[i] = bus.pulse_out[2];
        end
        checks++;
        if (tr !== 20'h04444) begin
            failures++; $display("FAIL both_toggle_trace got=%h exp=04444", tr);
        end
    endtask

    task automatic test_retrigger();
        logic [9:0] tr;
        bus.mode = 2'b00; bus.pulse_len = 4'd4; bus.retrig = 1'b1;
        tr = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bus.en[3] = 1'b1;
            if (i == 1) bus.en[3] = 1'b0;
            if (i == 2) bus.en[3] = 1'b1;
            tick();
            tr[i] = bus.pulse_out[3];
        end
        checks++;
        if (tr !== 10'h0FC) begin
            failures++; $display("FAIL retrig_trace got=%h exp=0fc", tr);
        end
        checks++;
        if (bus.missed !== 4'b0000) begin
            failures++; $display("FAIL retrig_missed got=%b exp=0000", bus.missed);
        end
        bus.en[3] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_missed_clear();
        logic [9:0] tr;
        logic [9:0] mtr;
        bus.mode = 2'b00; bus.pulse_len = 4'd4; bus.retrig = 1'b0;
        tr = '0; mtr = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bus.en[3] = 1'b1;
            if (i == 1) bus.en[3] = 1'b0;
            if (i == 2) bus.en[3] = 1'b1;
            tick();
            tr[i]  = bus.pulse_out[3];
            mtr[i] = bus.missed[3];
        end
        checks++;
        if (tr !== 10'h03C) begin
            failures++; $display("FAIL missed_pulse_trace got=%h exp=03c", tr);
        end
        checks++;
        if (mtr !== 10'h3F0) begin
            failures++; $display("FAIL missed_flag_trace got=%h exp=3f0", mtr);
        end
        bus.clr_missed = 1'b1;
        tick();
        bus.clr_missed = 1'b0;
        checks++;
        if (bus.missed !== 4'b0000) begin
            failures++; $display("FAIL clr_missed got=%b exp=0000", bus.missed);
        end
        bus.en[3] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        mtr = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bus.en[3] = 1'b1;
            if (i == 1) bus.en[3] = 1'b0;
            if (i == 2) bus.en[3] = 1'b1;
            if (i == 4) bus.clr_missed = 1'b1;
            if (i == 5) bus.clr_missed = 1'b0;
            tick();
            mtr[i] = bus.missed[3];
        end
        checks++;
        if (mtr !== 10'h3F0) begin
            failures++; $display("FAIL set_beats_clear got=%h exp=3f0", mtr);
        end
    endtask

    task automatic test_disable();
        logic [9:0] tr;
        logic       any;
        bus.clr_missed = 1'b1;
        tick();
        bus.clr_missed = 1'b0;
        bus.mode = 2'b00; bus.pulse_len = 4'd5;
        tr = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bus.en[0] = 1'b1;
            if (i == 4) bus.mode = 2'b11;
            tick();
            tr[i] = bus.pulse_out[0];
        end
        checks++;
        if (tr !== 10'h07C) begin
            failures++; $display("FAIL disable_completes got=%h exp=07c", tr);
        end
        any = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) bus.en[0] = 1'b0;
            if (i == 4) bus.en[0] = 1'b1;
            tick();
            any = any | (|bus.pulse_out);
        end
        checks++;
        if (any !== 1'b0) begin
            failures++; $display("FAIL disabled_ignores_edges got=%b exp=0", any);
        end
        bus.mode = 2'b00;
    endtask

    task automatic test_async_reset();
        logic [9:0] tr;
        bus.mode = 2'b00; bus.pulse_len = 4'd6; bus.retrig = 1'b0;
        bus.en[1] = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (bus.pulse_out[1] !== 1'b1) begin
            failures++; $display("FAIL pre_reset_pulse got=%b exp=1", bus.pulse_out[1]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.pulse_out !== 4'b0000) begin
            failures++; $display("FAIL async_reset_drop got=%b exp=0000", bus.pulse_out);
        end
        #1 rst = 1'b0;
        tr = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            tr[i] = bus.pulse_out[1];
        end
        checks++;
        if (tr !== 10'h0FC) begin
            failures++; $display("FAIL held_en_after_release got=%h exp=0fc", tr);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout sim_time=%0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rising_basic();
        test_falling();
        test_both();
        test_retrigger();
        test_missed_clear();
        test_disable();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_gen_multi.md
# pulse_gen_multi

Multi-channel, parametrised edge-to-pulse generator. Each channel watches one level input and emits a registered output pulse of programmable length on a selected edge type. Options cover input synchronisation, retriggering and a sticky missed-edge flag. It sits between asynchronous or slow control levels (buttons, enables, status lines) and logic that needs one clean, fixed-width strobe per event.

## Interface
- CHANNELS, 4: number of independent channels (≥1)
- LEN_BITS, 4: width of pulse_len; maximum pulse length is 2^LEN_BITS−1 cycles
- SYNC_STAGES, 2: synchroniser flops per input (0 = input already synchronous to clk)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  CHANNELS  per-channel level inputs
- mode  in  2  shared edge select: 00 rising, 01 falling, 10 both, 11 detection disabled
- pulse_len  in  LEN_BITS  shared pulse length in cycles; 0 is treated as 1
- retrig  in  1  1 = a qualifying edge during an active pulse restarts its length
- clr_missed  in  1  synchronous clear of all missed bits
- pulse_out  out  CHANNELS  registered output pulses
- missed  out  CHANNELS  sticky: a qualifying edge was dropped on that channel

## Operation
- Per channel datapath: en → SYNC_STAGES flops → s (synchronised level) → prev flop (s delayed 1 cycle).
- Edge qualification (combinational): rise = s & ~prev; fall = ~s & prev; qual selected by mode; mode 11 → qual = 0.
- Per-channel FSM, two states:
  - IDLE: pulse_out = 0. On qual: load cnt = max(pulse_len,1), go to PULSE.
  - PULSE: pulse_out = 1; cnt decrements each cycle; at cnt = 1 with no accepted edge, return to IDLE.
- Qualifying edge while in PULSE:
  - retrig = 1: cnt reloads with max(pulse_len,1); pulse_out stays high with no gap.
  - retrig = 0: edge dropped; missed[ch] set.
  - This includes the final cycle (cnt = 1), so there are never back-to-back pulses without a retrigger.
- pulse_len and retrig are sampled only at the cycle an edge is qualified. Changing them mid-pulse does not alter an active count unless a retrigger occurs.
- mode changes affect only future qualification; active pulses always run to completion (including under mode 11).
- missed: set has priority over clr_missed in the same cycle; otherwise clr_missed clears all bits.
- Channels are fully independent; simultaneous edges on all channels are all handled in the same cycle.

## Timing
- Reset (async assert, sync-safe release): all sync flops, prev, cnt = 0; FSM IDLE; pulse_out = 0; missed = 0.
- Reset mid-pulse: pulse_out drops immediately, without waiting for clk.
- Because sync and prev flops reset to 0, an en held high through reset release is seen as a rising edge S cycles after release.
- Latency: let t0 be the first clk edge that samples the new en level. pulse_out rises at edge t0+SYNC_STAGES (SYNC_STAGES = 0 → rises at t0).
- Pulse width: exactly max(pulse_len,1) cycles per accepted edge; each retrigger extends it to max(pulse_len,1) cycles after the retrigger edge.
- Edge detection rate: one qualification per channel per cycle. With mode = both, a 1-cycle en glitch that passes the synchroniser yields two qualifying edges in consecutive cycles.
- missed rises on the clk edge following the dropped qualification.

## Test plan
- Reset / basic, SYNC_STAGES=2, mode=00, pulse_len=3, ch0 en 0→1 sampled at t0 → pulse_out[0] high for edges t0+2 … t0+4 (3 cycles); other channels stay 0; missed=0.
- Falling and both modes, pulse_len=0:
  - mode=01, en 1→0 → one 1-cycle pulse; the rising edge produces nothing.
  - mode=10, en toggling every 4 cycles → one 1-cycle pulse per toggle.
- Retrigger, pulse_len=4, retrig=1, second rising edge (en 1→0→1 with mode=00) qualified 2 cycles into a pulse → pulse_out continuously high 6 cycles; missed stays 0.
- Missed / clear, same stimulus with retrig=0 → 4-cycle pulse, missed[ch]=1. clr_missed pulse → 0. Another dropped edge coinciding with clr_missed → missed stays 1.
- Disable mid-pulse and async reset:
  - mode→11 during a pulse → pulse completes; later edges ignored.
  - rst asserted between clk edges mid-pulse → pulse_out=0 immediately.
  - en held 1 across release → a pulse appears SYNC_STAGES cycles after release.
